mult_booth: RTL and testbench

- Sequential signed radix-4 Booth multiplier for the CPU multdiv unit.
- Uses the same start/ready/exception handshake as the sequential divider, so the pipeline stall logic treats both units the same way.
- Takes two WIDTH-bit two's-complement operands and returns the low WIDTH bits of the product.
- Flags overflow when the full product does not fit in WIDTH signed bits.

---
 rtl/mult_pkg.sv | 34 +++
 rtl/mult_booth_sel.sv | 30 +++
 rtl/mult_booth.sv | 124 ++++++++++++
 tb/tb_mult_booth.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, radix-4 digit
// select codes and the default operand width.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } booth_sel_e;

  // Radix-4 Booth recoding of {b[i+1], b[i], b[i-1]}
  function automatic booth_sel_e booth_decode(input logic [2:0] bits);
    booth_sel_e sel;
    case (bits)
      3'b001, 3'b010: sel = P1;
      3'b011:         sel = P2;
      3'b100:         sel = M2;
      3'b101, 3'b110: sel = M1;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mult_booth_sel.sv
// Radix-4 Booth recoder: turns three multiplier bits into the signed multiple
// {0, +A, +2A, -A, -2A}, sign-extended to WIDTH+2 bits.
module booth_sel
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic [2:0]       bits_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH+1:0] mult_o
);

  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] a2_ext;

  assign a_ext  = {{2{a_i[WIDTH-1]}}, a_i};
  assign a2_ext = {a_i[WIDTH-1], a_i, 1'b0};

  always_comb begin
    mult_o = '0;
    case (booth_decode(bits_i))
      P1:      mult_o = a_ext;
      P2:      mult_o = a2_ext;
      M1:      mult_o = -a_ext;
      M2:      mult_o = -a2_ext;
      default: mult_o = '0;
    endcase
  end

endmodule

// File: rtl/mult_booth.sv
// Sequential signed radix-4 Booth multiplier with start/ready/exception handshake.
// Optional early termination when the remaining Booth digits are all zero: MULT_EARLY_EXIT_EN.
module mult_booth
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             rdy,
  output logic             exp,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned ITER = WIDTH / 2;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam int unsigned PW   = 2 * WIDTH + 1;

  mult_state_e      state_q;
  logic [WIDTH-1:0] a_q;
  logic [PW-1:0]    prod_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             rdy_q;
  logic             exp_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH+1:0] sel_mult;
  logic [WIDTH+1:0] acc_sum;
  logic [PW-1:0]    prod_step;
  logic [PW-1:0]    prod_d;
  logic [CW-1:0]    cnt_d;
  logic             last_iter;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;
  logic             ovf;
`ifdef MULT_EARLY_EXIT_EN
  logic             all0;
  logic             all1;
`endif

  booth_sel #(.WIDTH(WIDTH)) u_sel (
    .bits_i (prod_q[2:0]),
    .a_i    (a_q),
    .mult_o (sel_mult)
  );

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    // Upper half is sign-extended by two bits before the add; the shift by two
    // then lands the WIDTH+2 bit sum back on top of the register.
    acc_sum   = {{2{prod_q[PW-1]}}, prod_q[PW-1:WIDTH+1]} + sel_mult;
    prod_step = {acc_sum, prod_q[WIDTH:2]};
`ifdef MULT_EARLY_EXIT_EN
    all0 = 1'b1;
    all1 = 1'b1;
    for (int unsigned i = 0; i <= WIDTH; i++) begin
      if (i + 2 * cnt_d <= WIDTH) begin
        all0 &= ~prod_step[i];
        all1 &= prod_step[i];
      end
    end
    last_iter = all0 | all1;
    prod_d    = last_iter ? PW'($signed(prod_step) >>> (2 * (ITER - cnt_d))) : prod_step;
`else
    last_iter = (cnt_d == CW'(ITER));
    prod_d    = prod_step;
`endif
    prod_hi = prod_d[PW-1:WIDTH+1];
    prod_lo = prod_d[WIDTH:1];
    ovf     = (prod_hi != {WIDTH{prod_lo[WIDTH-1]}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
      exp_q    <= 1'b0;
      result_q <= '0;
    end else begin
      rdy_q <= 1'b0;
      // A start in any state (re)loads the operands; an aborted run never signals rdy.
      if (ctrl_mult) begin
        state_q <= RUN;
        a_q     <= multiplicand;
        prod_q  <= {{WIDTH{1'b0}}, multiplier, 1'b0};
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
            if (last_iter) begin
              state_q  <= DONE;
              busy_q   <= 1'b0;
              rdy_q    <= 1'b1;
              result_q <= prod_lo;
              exp_q    <= ovf;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign rdy    = rdy_q;
  assign exp    = exp_q;
  assign result = result_q;

endmodule

// File: tb/tb_mult_booth.sv
// Directed self-checking bench for mult_booth (default and MULT_EARLY_EXIT_EN builds).
module tb_mult_booth;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         ctrl_mult;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         rdy;
  logic         exp_o;
  logic [W-1:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_booth #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .ctrl_mult    (ctrl_mult),
    .multiplicand (a),
    .multiplier   (b),
    .busy         (busy),
    .rdy          (rdy),
    .exp          (exp_o),
    .result       (result)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected cycles from start to rdy: fixed, or first point where remaining digits are all zero.
  function automatic int exp_lat(input logic [W-1:0] mb);
    logic signed [W:0] s;
    logic signed [W:0] v;
    int lat;
    s   = {mb, 1'b0};
    lat = W / 2 + 1;
`ifdef MULT_EARLY_EXIT_EN
    for (int k = W / 2; k >= 1; k--) begin
      v = s >>> (2 * k);
      if (v == '0 || v == '1) lat = k + 1;
    end
`endif
    return lat;
  endfunction

  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    a         = av;
    b         = bv;
    ctrl_mult = 1'b1;
    tick();
    ctrl_mult = 1'b0;
    a         = $urandom;
    b         = $urandom;
  endtask

  // Called in cycle 1 after a start; walks exactly to the expected rdy cycle.
  task automatic wait_done(input string tag, input logic [W-1:0] bv, input logic [W-1:0] er,
                           input logic ee, input bit chk_busy);
    int  lat;
    bit  early_rdy;
    bit  busy_bad;
    lat       = exp_lat(bv);
    early_rdy = 1'b0;
    busy_bad  = 1'b0;
    for (int c = 1; c < lat; c++) begin
      if (rdy) early_rdy = 1'b1;
      if (chk_busy && !busy) busy_bad = 1'b1;
      tick();
    end
    check({tag, ".early_rdy"}, {31'b0, early_rdy}, 32'd0);
    if (chk_busy) check({tag, ".busy_run"}, {31'b0, busy_bad}, 32'd0);
    check({tag, ".rdy"}, {31'b0, rdy}, 32'd1);
    check({tag, ".busy_done"}, {31'b0, busy}, 32'd0);
    check({tag, ".result"}, result, er);
    check({tag, ".exp"}, {31'b0, exp_o}, {31'b0, ee});
    tick();
    check({tag, ".rdy_pulse"}, {31'b0, rdy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] er, input logic ee, input bit chk_busy);
    launch(av, bv);
    wait_done(tag, bv, er, ee, chk_busy);
  endtask

  initial begin
    bit seen;
    reset     = 1'b1;
    ctrl_mult = 1'b0;
    a         = '0;
    b         = '0;
    tick();
    tick();
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.rdy", {31'b0, rdy}, 32'd0);
    check("rst.exp", {31'b0, exp_o}, 32'd0);
    check("rst.result", result, 32'd0);
    reset = 1'b0;
    tick();

    run_op("3x5",       32'd3,        32'd5,        32'd15,         1'b0, 1'b1);
    run_op("m7x6",      32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6,   1'b0, 1'b1);
    run_op("minxm1",    32'h80000000, 32'hFFFFFFFF, 32'h80000000,   1'b1, 1'b1);
    run_op("64kx64k",   32'd65536,    32'd65536,    32'd0,          1'b1, 1'b1);
    run_op("1000xm1000",32'd1000,     32'hFFFFFC18, 32'hFFF0BDC0,   1'b0, 1'b1);
    run_op("minxmin",   32'h80000000, 32'h80000000, 32'd0,          1'b1, 1'b1);
    run_op("0xk",       32'd0,        32'h12345678, 32'd0,          1'b0, 1'b1);
    run_op("maxx2",     32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE,   1'b1, 1'b1);
    run_op("fit",       32'h00010000, 32'h00007FFF, 32'h7FFF0000,   1'b0, 1'b1);
    run_op("m1xm1",     32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,          1'b0, 1'b1);

    // New start keeps the previous result; restart in cycle 5 aborts the first op
    launch(32'd5, 32'h55555555);
    check("hold.result", result, 32'd1);
    seen = 1'b0;
    for (int c = 1; c < 5; c++) begin
      if (rdy) seen = 1'b1;
      tick();
    end
    check("restart.pre_rdy", {31'b0, seen}, 32'd0);
    launch(32'd2, 32'd9);
    wait_done("restart", 32'd9, 32'd18, 1'b0, 1'b1);

    // Reset in cycle 8 of a running op
    launch(32'd3, 32'h55555555);
    for (int c = 1; c < 8; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst.busy", {31'b0, busy}, 32'd0);
    check("midrst.rdy", {31'b0, rdy}, 32'd0);
    check("midrst.result", result, 32'd0);
    check("midrst.exp", {31'b0, exp_o}, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rdy || busy) seen = 1'b1;
      tick();
    end
    check("midrst.quiet", {31'b0, seen}, 32'd0);
    run_op("post_rst", 32'd3, 32'd5, 32'd15, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
